// File: rtl/wide_add_pkg.sv
// wide_add_pkg: shared FSM encoding and slice width for the wide add sequencer
package wide_add_pkg;
    localparam int SLICE_W = 16;
    typedef enum logic [1:0] {IDLE, RUN, DONE} wadd_state_t;
endpackage

// File: rtl/prefix_adder16bit.sv
// prefix_adder16bit: combinational 16-bit Kogge-Stone adder with carry-in
//   a, b  : addends      cin  : carry-in
//   sum   : a+b+cin      cout : carry out of bit 15
module prefix_adder16bit
    import wide_add_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);
    logic [4:0][SLICE_W-1:0] gk;
    logic [4:0][SLICE_W-1:0] pk;
    always_comb begin
        pk[0] = a ^ b;
        // cin folded into bit 0's generate so every prefix G[i] is the carry out of bit i
        gk[0] = (a & b) | {{(SLICE_W-1){1'b0}}, pk[0][0] & cin};
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < SLICE_W; i++) begin
                gk[l+1][i] = gk[l][i];
                pk[l+1][i] = pk[l][i];
                if (i >= (1 << l)) begin
                    gk[l+1][i] = gk[l][i] | (pk[l][i] & gk[l][i-(1<<l)]);
                    pk[l+1][i] = pk[l][i] & pk[l][i-(1<<l)];
                end
            end
        end
    end
    assign sum  = pk[0] ^ {gk[4][SLICE_W-2:0], cin};
    assign cout = gk[4][SLICE_W-1];
endmodule

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: multi-word add/subtract, one 16-bit slice per clock, LSW first
//   clk, rst_n (sync, active-low)
//   in_valid/in_ready : operand handshake, in_a/in_b/in_cin/in_sub operands
//   out_valid/out_ready : result handshake, out_sum/out_cout/out_ovf results
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int N     = SLICE_W * WORDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_cin,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_cout,
    output logic         out_ovf
);
    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
    wadd_state_t          state_q;
    logic [IW-1:0]        idx_q;
    logic [N-1:0]         a_q;
    logic [N-1:0]         b_q;
    logic                 carry_q;
    logic [SLICE_W-1:0]   slice_sum;
    logic                 slice_cout;
    prefix_adder16bit u_add (
        .a    (a_q[SLICE_W*idx_q +: SLICE_W]),
        .b    (b_q[SLICE_W*idx_q +: SLICE_W]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );
    assign in_ready = (state_q == IDLE) && rst_n;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= in_a;
                    b_q     <= in_sub ? ~in_b : in_b;
                    carry_q <= in_sub | in_cin;
                    idx_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    out_sum[SLICE_W*idx_q +: SLICE_W] <= slice_sum;
                    carry_q <= slice_cout;
                    if (idx_q == LAST) begin
                        out_cout  <= slice_cout;
                        out_ovf   <= (a_q[N-1] == b_q[N-1]) && (slice_sum[SLICE_W-1] != a_q[N-1]);
                        out_valid <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: directed self-checking bench for the 4-word add/sub sequencer
module tb_wide_add_sequencer;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [63:0] in_a = 0;
    logic [63:0] in_b = 0;
    logic        in_cin = 0;
    logic        in_sub = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [63:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    wide_add_sequencer #(.WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic start(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1;
        step();
        in_valid = 0;
    endtask
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub,
                          output logic [63:0] s, output logic c, output logic v, output int lat);
        start(a, b, cin, sub);
        wait_valid(lat);
        s = out_sum; c = out_cout; v = out_ovf;
        out_ready = 1;
        step();
        out_ready = 0;
    endtask
    task automatic test_reset();
        step();
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        tests++; if ({out_valid, out_sum, out_cout, out_ovf} !== 67'd0) begin fails++; $display("FAIL reset_outputs got v=%b s=%h c=%b o=%b exp all 0", out_valid, out_sum, out_cout, out_ovf); end
        rst_n = 1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got %b exp 1", in_ready); end
    endtask
    task automatic test_add();
        logic [63:0] s; logic c, v; int lat;
        run_op(64'h0000_0000_0000_FFFF, 64'd1, 0, 0, s, c, v, lat);
        tests++; if (lat !== 4) begin fails++; $display("FAIL add1_latency got %0d exp 4", lat); end
        tests++; if ({s, c, v} !== {64'h0000_0000_0001_0000, 1'b0, 1'b0}) begin fails++; $display("FAIL add1 got s=%h c=%b o=%b exp s=0000000000010000 c=0 o=0", s, c, v); end
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, s, c, v, lat);
        tests++; if ({s, c, v} !== {64'd0, 1'b1, 1'b0}) begin fails++; $display("FAIL add_ripple got s=%h c=%b o=%b exp s=0 c=1 o=0", s, c, v); end
        run_op(64'h0000_0001_FFFF_0001, 64'h0000_0000_0001_0001, 1, 0, s, c, v, lat);
        tests++; if ({s, c, v} !== {64'h0000_0002_0000_0003, 1'b0, 1'b0}) begin fails++; $display("FAIL add_cin got s=%h c=%b o=%b exp s=0000000200000003 c=0 o=0", s, c, v); end
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, s, c, v, lat);
        tests++; if ({s, c, v} !== {64'h8000_0000_0000_0000, 1'b0, 1'b1}) begin fails++; $display("FAIL add_ovf got s=%h c=%b o=%b exp s=8000000000000000 c=0 o=1", s, c, v); end
    endtask
    task automatic test_sub();
        logic [63:0] s; logic c, v; int lat;
        run_op(64'd5, 64'd7, 0, 1, s, c, v, lat);
        tests++; if ({s, c, v} !== {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0}) begin fails++; $display("FAIL sub_neg got s=%h c=%b o=%b exp s=fffffffffffffffe c=0 o=0", s, c, v); end
        run_op(64'd7, 64'd5, 1, 1, s, c, v, lat);
        tests++; if ({s, c, v} !== {64'd2, 1'b1, 1'b0}) begin fails++; $display("FAIL sub_pos got s=%h c=%b o=%b exp s=2 c=1 o=0", s, c, v); end
        run_op(64'h8000_0000_0000_0000, 64'd1, 0, 1, s, c, v, lat);
        tests++; if ({s, c, v} !== {64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1}) begin fails++; $display("FAIL sub_ovf got s=%h c=%b o=%b exp s=7fffffffffffffff c=1 o=1", s, c, v); end
    endtask
    task automatic test_backpressure();
        logic [63:0] s; int lat; int bad;
        start(64'd100, 64'd23, 0, 0);
        wait_valid(lat);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid got %b exp 1", out_valid); end
        in_a = 64'd3; in_b = 64'd4; in_valid = 1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid !== 1'b1 || out_sum !== 64'd123 || in_ready !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL bp_hold got %0d bad cycles exp 0 (sum=%h)", bad, out_sum); end
        out_ready = 1;
        step();
        out_ready = 0;
        tests++; if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL bp_release got valid/ready=%b exp 01", {out_valid, in_ready}); end
        step();
        in_valid = 0;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_accept got ready=%b exp 0", in_ready); end
        wait_valid(lat);
        s = out_sum;
        tests++; if ({s, lat} !== {64'd7, 32'd4}) begin fails++; $display("FAIL bp_next got s=%h lat=%0d exp s=7 lat=4", s, lat); end
        out_ready = 1;
        step();
        out_ready = 0;
    endtask
    task automatic test_mid_reset();
        int seen;
        start(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0);
        step();
        step();
        rst_n = 0;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL midrst_ready_low got %b exp 0", in_ready); end
        step();
        rst_n = 1;
        #1;
        tests++; if ({out_valid, out_sum, out_cout, out_ovf} !== 67'd0) begin fails++; $display("FAIL midrst_outputs got v=%b s=%h c=%b o=%b exp all 0", out_valid, out_sum, out_cout, out_ovf); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got %b exp 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_no_result got %0d valid cycles exp 0", seen); end
    endtask
    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
